// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_seq_pkg                                             |
// | Purpose  : Shared command codes, FSM state type and helpers for    |
// |            the ALU sequencer and its register file.                |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package alu_seq_pkg;

  localparam int DATA_W    = 8;
  localparam int NREGS     = 4;
  localparam int REG_IDX_W = $clog2(NREGS);

  // ALU command codes; the sequencer only passes these through.
  localparam logic [3:0] CMD_ADD    = 4'h0;
  localparam logic [3:0] CMD_SUB    = 4'h1;
  localparam logic [3:0] CMD_AND    = 4'h2;
  localparam logic [3:0] CMD_OR     = 4'h3;
  localparam logic [3:0] CMD_XOR    = 4'h4;
  localparam logic [3:0] CMD_NOT_A  = 4'h5;
  localparam logic [3:0] CMD_SHL    = 4'h6;
  localparam logic [3:0] CMD_SHR    = 4'h7;
  localparam logic [3:0] CMD_PASS_B = 4'h8;
  localparam logic [3:0] CMD_ADC    = 4'h9;
  localparam logic [3:0] CMD_SBB    = 4'hA;
  localparam logic [3:0] CMD_NAND   = 4'hB;
  localparam logic [3:0] CMD_NOR    = 4'hC;
  localparam logic [3:0] CMD_XNOR   = 4'hD;
  localparam logic [3:0] CMD_AND_TC = 4'hE;
  localparam logic [3:0] CMD_NOR_TC = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Only arithmetic commands produce a meaningful carry/borrow.
  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_ADC) || (cmd == CMD_SBB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_seq_regfile                                         |
// | Purpose  : NREGS x DATA_W register file, two combinational read    |
// |            ports, one synchronous write port, synchronous clear.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module alu_seq_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);

  logic [NREGS-1:0][DATA_W-1:0] mem_q;
  logic [NREGS-1:0][DATA_W-1:0] mem_d;

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

  // Next-state of the storage: single write port, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage flops; reset clears every entry and overrides any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_sequencer                                           |
// | Purpose  : Accepts register/immediate instructions, drives an      |
// |            external combinational ALU, writes back and returns the |
// |            result with carry/zero flags over a valid/ready port.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module alu_sequencer #(
  parameter int DATA_W = alu_seq_pkg::DATA_W,
  parameter int NREGS  = alu_seq_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_cmd,
  input  logic [$clog2(NREGS)-1:0] in_ra,
  input  logic [$clog2(NREGS)-1:0] in_rb,
  input  logic                     in_use_imm,
  input  logic [DATA_W-1:0]        in_imm,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic                     in_wb,
  output logic [3:0]               alu_command,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic                     res_carry,
  output logic                     res_zero,
  output logic                     busy
);

  import alu_seq_pkg::*;

  localparam int IDX_W = $clog2(NREGS);

  state_e              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [IDX_W-1:0]    rd_q, rd_d;
  logic                wb_q, wb_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                c_q, c_d;
  logic                z_q, z_d;

  logic [DATA_W-1:0]   rf_a;
  logic [DATA_W-1:0]   rf_b;
  logic                rf_we;

  // Write-back happens only at the end of EXEC and never while reset is high.
  assign rf_we = (state_q == EXEC) && wb_q && !rst;

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (in_ra),
    .rd_addr_b (in_rb),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .wr_en     (rf_we),
    .wr_addr   (rd_q),
    .wr_data   (alu_out)
  );

  // Next-state logic: operand capture in IDLE, result capture in EXEC,
  // hand-off in RESP. Everything holds by default so ALU inputs never glitch.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    wb_d       = wb_q;
    res_data_d = res_data_q;
    c_d        = c_q;
    z_d        = z_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cmd_d   = in_cmd;
          a_d     = rf_a;
          b_d     = in_use_imm ? in_imm : rf_b;
          rd_d    = in_rd;
          wb_d    = in_wb;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d = alu_out;
        z_d        = (alu_out == '0);
        if (is_arith(cmd_q)) begin
          c_d = alu_carry;
        end
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      wb_q       <= 1'b0;
      res_data_q <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      wb_q       <= wb_d;
      res_data_q <= res_data_d;
      c_q        <= c_d;
      z_q        <= z_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign res_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign alu_command = cmd_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign res_data    = res_data_q;
  assign res_carry   = c_q;
  assign res_zero    = z_q;

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the 8-bit ALU command interface: accepts instructions over a valid/ready handshake and drives the ALU's command/a/b inputs.
- Captures the ALU's out/carry, writes back into a small register file, and returns the result plus flags over a second valid/ready handshake.
- Sits between an instruction source (bench or future controller) and the combinational ALU instance.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- NREGS, 4, register-file depth; register index width is clog2(NREGS) = 2.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  instruction valid.
- in_ready  output  1  sequencer can accept an instruction.
- in_cmd  input  4  ALU command code, passed through unchanged.
- in_ra  input  2  register index for operand A.
- in_rb  input  2  register index for operand B.
- in_use_imm  input  1  1 = operand B is in_imm; 0 = operand B is rf[in_rb].
- in_imm  input  8  immediate operand.
- in_rd  input  2  destination register.
- in_wb  input  1  1 = write the result to rf[in_rd].
- alu_command  output  4  to ALU command.
- alu_a  output  8  to ALU operand a.
- alu_b  output  8  to ALU operand b.
- alu_out  input  8  from ALU result.
- alu_carry  input  1  from ALU carry/borrow.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  8  captured result.
- res_carry  output  1  carry flag C.
- res_zero  output  1  zero flag Z.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE; all rf entries 0x00; alu_command/alu_a/alu_b 0; res_valid 0; res_data 0x00; C 0; Z 0; busy 0. in_ready is 1 during IDLE after reset.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - register alu_command <= in_cmd and alu_a <= rf[in_ra];
    - register alu_b <= (in_use_imm ? in_imm : rf[in_rb]);
    - latch in_rd and in_wb;
    - go to EXEC.
  - EXEC (exactly 1 cycle): ALU inputs are stable from registers. At the end of the cycle:
    - res_data <= alu_out;
    - Z <= (alu_out == 0);
    - C <= alu_carry only if the command is arithmetic (0x0, 0x1, 0x9, 0xA); otherwise C is retained;
    - if wb is set, rf[rd] <= alu_out;
    - go to RESP.
  - RESP: res_valid = 1. res_data, res_carry and res_zero are held stable. On res_ready go to IDLE, with res_valid low the next cycle.
- Latency: accept edge to res_valid high is 2 cycles. Peak throughput is 1 instruction per 3 cycles.
- in_ready is 0 in EXEC and RESP. in_valid in those states is ignored and nothing is latched.
- ALU outputs hold their last value outside EXEC; no glitching to 0.
- Read-after-write: the register write completes at the end of EXEC, so the next accepted instruction sees the new value.
- ra == rd is legal: the old value is read and the new value is written.
- Commands are pure pass-through. All 16 codes are valid; the sequencer does not decode them except for the C-update rule.
- Reset mid-operation: rst in any state wins over everything else.
  - No register-file write occurs in a cycle where rst is high.
  - The in-flight result is discarded and all reset values apply on the next cycle.
- Simultaneous res_ready with entry into RESP: ready is evaluated only while in RESP; res_valid is asserted for at least 1 cycle.

Decomposition:
- Package alu_seq_pkg:
  - command constants CMD_ADD = 0x0 through CMD_NOR_TC = 0xF;
  - state enum {IDLE, EXEC, RESP};
  - function is_arith(cmd), true for 0x0/0x1/0x9/0xA;
  - DATA_W and register-index width localparams.
- Sub-module alu_seq_regfile: NREGS x DATA_W, two combinational read ports, one synchronous write port, synchronous reset clears all entries.
- The ALU is instantiated at the parent level, not inside alu_sequencer.

Test Plan:
- The bench uses an ALU stub: alu_out = (alu_a + alu_b)[7:0], alu_carry = bit 8, for every command.
- Reset: hold rst for 2 cycles -> in_ready = 1, res_valid = 0, busy = 0, rf[0..3] = 0x00, alu_a = alu_b = 0.
- Immediate load: cmd 0x0, ra 0, use_imm 1, imm 0x2A, rd 1, wb 1 -> res_valid 2 cycles after accept; res_data 0x2A, C 0, Z 0; rf[1] = 0x2A.
- Carry/flag rules:
  - cmd 0x0, ra 1, imm 0xFF -> res_data 0x29, C 1.
  - then cmd 0x2, ra 0, imm 0x00 -> res_data 0x00, Z 1, C stays 1.
- Backpressure: hold res_ready low for 5 cycles while pulsing in_valid -> res_valid and res_data stable, in_ready 0, no new instruction latched. Raise res_ready -> in_ready 1 on the next cycle.
- Reset during EXEC: rst asserted in the EXEC cycle of a wb = 1 instruction to rd 2 -> rf[2] stays 0x00, res_valid 0, state IDLE next cycle.
- wb = 0: cmd 0x0, ra 1, imm 0x01, rd 1, wb 0 -> res_data 0x2B returned, rf[1] unchanged at 0x2A.
